// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the fetch/decode/execute/writeback controller:
// opcodes, ALU ops, FSM states, instruction field positions and the decoded-instruction bundle.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LI   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_XOR    = 3'd4;
  localparam logic [2:0] ALU_PASS_B = 3'd7;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 7;
  localparam int TGT_LSB = 0;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_e;

  typedef struct packed {
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] imm;
    logic [7:0] tgt;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       wb_sel;
    logic       writes_reg;
    logic       is_branch;
    logic       is_jump;
    logic       is_halt;
    logic       is_illegal;
  } dec_t;

  function automatic logic [7:0] sext6(input logic [5:0] v);
    return {{2{v[5]}}, v};
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Instruction-fetch port: controller (master) issues req/addr, memory (slave) returns ack/rdata.
interface cpu_ctrl_fsm_if #(parameter int PC_W = 8);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/cpu_ctrl_fsm_instr_decode.sv
// Purely combinational instruction decode from the IR; every control field is a
// function of the instruction word alone so it holds steady for the whole instruction.
module instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);
  logic [3:0] op;
  assign op = ir[OP_MSB:OP_LSB];

  always_comb begin
    dec     = '0;
    dec.rd  = ir[RD_MSB:RD_LSB];
    dec.rs1 = ir[RS1_MSB:RS1_LSB];
    dec.rs2 = ir[RS2_MSB:RS2_LSB];
    dec.imm = sext6(ir[IMM_MSB:IMM_LSB]);
    dec.tgt = ir[TGT_MSB:TGT_LSB];
    case (op)
      OP_NOP:  ;
      OP_ADD:  begin dec.alu_op = ALU_ADD; dec.writes_reg = 1'b1; end
      OP_SUB:  begin dec.alu_op = ALU_SUB; dec.writes_reg = 1'b1; end
      OP_AND:  begin dec.alu_op = ALU_AND; dec.writes_reg = 1'b1; end
      OP_OR:   begin dec.alu_op = ALU_OR;  dec.writes_reg = 1'b1; end
      OP_XOR:  begin dec.alu_op = ALU_XOR; dec.writes_reg = 1'b1; end
      OP_ADDI: begin dec.alu_op = ALU_ADD; dec.alu_src_imm = 1'b1; dec.writes_reg = 1'b1; end
      OP_LI: begin
        dec.alu_op      = ALU_PASS_B;
        dec.alu_src_imm = 1'b1;
        dec.wb_sel      = 1'b1;
        dec.writes_reg  = 1'b1;
      end
      // Equality test is a subtract; the FSM looks at alu_zero.
      OP_BEQ:  begin dec.alu_op = ALU_SUB; dec.is_branch = 1'b1; end
      OP_JMP:  dec.is_jump = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.is_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller; owns the PC and IR and
// drives register-file addressing and ALU control decoded from the IR.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cpu_ctrl_fsm_if.master        imem,
  output logic [2:0]            read_reg1,
  output logic [2:0]            read_reg2,
  output logic [2:0]            write_reg,
  output logic                  reg_write,
  output logic [2:0]            alu_op,
  output logic                  alu_src_imm,
  output logic [7:0]            imm,
  output logic                  wb_sel,
  input  logic                  alu_zero,
  output logic                  halted,
  output logic                  illegal
);
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;
  dec_t            dec;
  logic [PC_W-1:0] br_off;

  instr_decode u_dec (.ir(ir_q), .dec(dec));

  assign br_off = PC_W'($signed(dec.imm));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: if (imem.imem_ack) begin
        ir_d    = imem.imem_rdata;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        // pc already points past the branch, so the offset is relative to pc_next.
        if (dec.is_branch && alu_zero) pc_d = pc_q + br_off;
        if (dec.is_jump) pc_d = PC_W'(dec.tgt);
        if (dec.is_illegal) illegal_d = 1'b1;
        if (dec.is_halt)         state_d = S_HALT;
        else if (dec.writes_reg) state_d = S_WRITEBACK;
        else                     state_d = S_FETCH;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // Request is gated by rst_n so it drops the moment reset asserts.
  assign imem.imem_req  = rst_n && (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign read_reg1      = dec.rs1;
  assign read_reg2      = dec.rs2;
  assign write_reg      = dec.rd;
  assign reg_write      = (state_q == S_WRITEBACK);
  assign alu_op         = dec.alu_op;
  assign alu_src_imm    = dec.alu_src_imm;
  assign imm            = dec.imm;
  assign wb_sel         = dec.wb_sel;
  assign halted         = (state_q == S_HALT);
  assign illegal        = illegal_q;
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench: each acked fetch pushes expected decode, writeback and next-fetch
// entries; a negedge monitor pops and compares them as the controller produces them.
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  localparam int PC_W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] read_reg1, read_reg2, write_reg, alu_op;
  logic       reg_write, alu_src_imm, wb_sel, alu_zero, halted, illegal;
  logic [7:0] imm;

  cpu_ctrl_fsm_if #(.PC_W(PC_W)) bus ();

  cpu_ctrl_fsm #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
    .reg_write(reg_write), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .imm(imm), .wb_sel(wb_sel), .alu_zero(alu_zero),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] aop;
    logic [7:0] im;
  } dec_exp_t;

  typedef struct packed {
    logic [2:0] rd;
    logic [2:0] aop;
    logic [7:0] im;
    logic       wsel;
    logic       srci;
  } wr_exp_t;

  dec_exp_t        dec_q[$];
  wr_exp_t         wr_q[$];
  logic [PC_W-1:0] fetch_q[$];
  logic [15:0]     mem [256];

  int       n_chk = 0;
  int       n_bad = 0;
  int       beq_cnt = 0;
  logic     ack_en = 1'b1;
  logic     prev_req = 1'b0;
  logic     dec_next = 1'b0;
  logic     found;
  dec_exp_t de;
  wr_exp_t  we;
  logic [15:0] w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference model of one instruction's observable effects.
  task automatic expect_instr(input logic [PC_W-1:0] a, input logic [15:0] iw, input logic z);
    logic [3:0]      op;
    logic [7:0]      im;
    logic [2:0]      aop;
    logic [PC_W-1:0] nxt;
    op  = iw[15:12];
    im  = {{2{iw[5]}}, iw[5:0]};
    nxt = a + 8'd1;
    case (op)
      4'h1: aop = 3'd0;
      4'h2: aop = 3'd1;
      4'h3: aop = 3'd2;
      4'h4: aop = 3'd3;
      4'h5: aop = 3'd4;
      4'h7: aop = 3'd7;
      4'h8: aop = 3'd1;
      default: aop = 3'd0;
    endcase
    dec_q.push_back('{rs1: iw[8:6], rs2: iw[5:3], aop: aop, im: im});
    if (op >= 4'h1 && op <= 4'h7)
      wr_q.push_back('{rd: iw[11:9], aop: aop, im: im, wsel: (op == 4'h7),
                       srci: (op == 4'h6 || op == 4'h7)});
    if (op == 4'h8 && z) nxt = nxt + im;
    if (op == 4'h9) nxt = iw[7:0];
    if (op != 4'hF) fetch_q.push_back(nxt);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req       = 1'b0;
      dec_next       = 1'b0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      alu_zero       = 1'b0;
    end else begin
      if (dec_next && dec_q.size() > 0) begin
        de = dec_q.pop_front();
        chk("dec_rs1", 32'(read_reg1), 32'(de.rs1));
        chk("dec_rs2", 32'(read_reg2), 32'(de.rs2));
        chk("dec_aluop", 32'(alu_op), 32'(de.aop));
        chk("dec_imm", 32'(imm), 32'(de.im));
        chk("dec_req", 32'(bus.imem_req), 32'd0);
      end
      dec_next = 1'b0;
      if (reg_write) begin
        if (wr_q.size() == 0) chk("spurious_wr", 32'(reg_write), 32'd0);
        else begin
          we = wr_q.pop_front();
          chk("wb_rd", 32'(write_reg), 32'(we.rd));
          chk("wb_aluop", 32'(alu_op), 32'(we.aop));
          chk("wb_imm", 32'(imm), 32'(we.im));
          chk("wb_sel", 32'(wb_sel), 32'(we.wsel));
          chk("wb_srcimm", 32'(alu_src_imm), 32'(we.srci));
        end
      end
      if (bus.imem_req && !prev_req) begin
        if (fetch_q.size() == 0) chk("spurious_fetch", 32'(bus.imem_req), 32'd0);
        else chk("fetch_addr", 32'(bus.imem_addr), 32'(fetch_q.pop_front()));
      end
      prev_req     = bus.imem_req;
      bus.imem_ack = 1'b0;
      if (bus.imem_req && ack_en) begin
        w = mem[bus.imem_addr];
        if (w[15:12] == 4'h8) begin
          alu_zero = (beq_cnt == 0);
          beq_cnt++;
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        dec_next       = 1'b1;
        expect_instr(bus.imem_addr, w, alu_zero);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h1298;  // ADD r1,r2,r3
    mem[1]  = 16'h7E3F;  // LI r7,-1
    mem[2]  = 16'h9005;  // JMP 5
    mem[3]  = 16'h6A45;  // ADDI r5,r1,5
    mem[4]  = 16'h2128;  // SUB r0,r4,r5
    mem[5]  = 16'h803D;  // BEQ r0,r7,-3 (taken first, not taken second)
    mem[6]  = 16'h5FF8;  // XOR r7,r7,r7
    mem[7]  = 16'hA000;  // illegal
    mem[8]  = 16'h34E0;  // AND r2,r3,r4
    mem[9]  = 16'h4770;  // OR r3,r5,r6
    mem[10] = 16'h90FE;  // JMP 0xFE, NOPs at FE/FF wrap to 0

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_regwrite", 32'(reg_write), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_ctrl", 32'({read_reg1, read_reg2, write_reg, alu_op, imm, wb_sel, alu_src_imm}), 32'd0);
    fetch_q.push_back(8'h00);
    @(posedge clk); #2 rst_n = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr == 8'hFF) found = 1'b1;
    end
    chk("reach_ff", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr == 8'h00) found = 1'b1;
    end
    chk("wrap_to_0", 32'(found), 32'd1);
    chk("illegal_sticky", 32'(illegal), 32'd1);

    // ADD at 0 is acked here; three edges later it is in WRITEBACK.
    repeat (3) @(posedge clk);
    #1;
    chk("wb_before_rst", 32'(reg_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wb_regwrite", 32'(reg_write), 32'd0);
    chk("rst_wb_req", 32'(bus.imem_req), 32'd0);
    chk("rst_wb_illegal", 32'(illegal), 32'd0);
    chk("rst_wb_addr", 32'(bus.imem_addr), 32'd0);
    dec_q.delete();
    wr_q.delete();
    fetch_q.delete();
    mem[0]     = 16'h90F0;  // JMP 0xF0
    mem[8'hF0] = 16'hF000;  // HALT
    ack_en     = 1'b0;
    fetch_q.push_back(8'h00);
    @(posedge clk); #2 rst_n = 1'b1;

    repeat (5) begin
      @(negedge clk);
      chk("stall_req", 32'(bus.imem_req), 32'd1);
      chk("stall_addr", 32'(bus.imem_addr), 32'd0);
    end
    @(posedge clk); #1 ack_en = 1'b1;

    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (halted) found = 1'b1;
    end
    chk("halt_seen", 32'(found), 32'd1);
    repeat (20) begin
      @(negedge clk);
      chk("halt_req", 32'(bus.imem_req), 32'd0);
      chk("halt_flag", 32'(halted), 32'd1);
    end
    chk("fetch_q_left", 32'(fetch_q.size()), 32'd0);
    chk("wr_q_left", 32'(wr_q.size()), 32'd0);
    chk("dec_q_left", 32'(dec_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
